// File: rtl/col_readout_ctrl.sv
// Column readout controller: after each accepted L1A and a programmable delay, it
// drains hit words from the bottom cell of the column into a small output FIFO.
// It then appends a trailer word that carries the event number, column ID and hit count.
module col_readout_ctrl #(
    parameter int BCSTWIDTH = 27,
    parameter int FIFODEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [3:0]           colID,
    input  logic [7:0]           readDelay,
    input  logic                 l1a,
    input  logic [BCSTWIDTH-1:0] bcstIn,
    output logic [BCSTWIDTH-1:0] colBCST,
    input  logic [4:0]           colHits,
    input  logic [45:0]          colData,
    output logic                 colRead,
    output logic [45:0]          outData,
    output logic                 outLast,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [7:0]           droppedL1A
);

    localparam int PTRW = (FIFODEPTH > 1) ? $clog2(FIFODEPTH) : 1;
    localparam int CNTW = $clog2(FIFODEPTH + 1);

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN, TRAILER} stateT;

    stateT            state;
    logic [7:0]       dlyCnt;
    logic [4:0]       hitCnt;
    logic [7:0]       l1aCnt;

    logic [46:0]      fifoMem [FIFODEPTH];
    logic [PTRW-1:0]  wrPtr;
    logic [PTRW-1:0]  rdPtr;
    logic [CNTW-1:0]  fifoCount;

    logic             notFull;
    logic             pushTrailer;
    logic             push;
    logic             pop;
    logic [46:0]      pushWord;
    logic [46:0]      headWord;

    // Space is judged on the registered count only, so a same-cycle pop never frees a slot early.
    assign notFull     = fifoCount < CNTW'(FIFODEPTH);
    assign colRead     = (state == DRAIN) && (colHits != 5'd0) && notFull;
    assign pushTrailer = (state == TRAILER) && notFull;
    assign push        = colRead || pushTrailer;
    assign pushWord    = pushTrailer ? {29'b0, l1aCnt, colID, hitCnt, 1'b1}
                                     : {colData, 1'b0};

    assign outValid = (fifoCount != '0);
    assign pop      = outValid && outReady;
    assign headWord = outValid ? fifoMem[rdPtr] : '0;
    assign outData  = headWord[46:1];
    assign outLast  = headWord[0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            dlyCnt     <= '0;
            hitCnt     <= '0;
            l1aCnt     <= '0;
            droppedL1A <= '0;
            colBCST    <= '0;
        end else begin
            colBCST <= bcstIn;
            if (l1a && state != IDLE && droppedL1A != 8'hFF)
                droppedL1A <= droppedL1A + 8'd1;
            if (colRead && hitCnt != 5'h1F)
                hitCnt <= hitCnt + 5'd1;
            case (state)
                IDLE: begin
                    if (l1a) begin
                        dlyCnt <= readDelay;
                        hitCnt <= '0;
                        l1aCnt <= l1aCnt + 8'd1;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (dlyCnt == 8'd0)
                        state <= DRAIN;
                    else
                        dlyCnt <= dlyCnt - 8'd1;
                end
                DRAIN: begin
                    if (colHits == 5'd0)
                        state <= TRAILER;
                end
                TRAILER: begin
                    if (notFull)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage carries no reset; empty-state outputs are masked by outValid instead.
    always_ff @(posedge clk) begin
        if (push)
            fifoMem[wrPtr] <= pushWord;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
        end else begin
            if (push)
                wrPtr <= (wrPtr == PTRW'(FIFODEPTH - 1)) ? '0 : wrPtr + PTRW'(1);
            if (pop)
                rdPtr <= (rdPtr == PTRW'(FIFODEPTH - 1)) ? '0 : rdPtr + PTRW'(1);
            case ({push, pop})
                2'b10:   fifoCount <= fifoCount + CNTW'(1);
                2'b01:   fifoCount <= fifoCount - CNTW'(1);
                default: fifoCount <= fifoCount;
            endcase
        end
    end

endmodule

// File: tb/tb_col_readout_ctrl.sv
// Bench for col_readout_ctrl: an event-level model predicts colRead and the output word
// stream every cycle, backed by directed scenarios with hand-computed words.
module tb_col_readout_ctrl;

    localparam int BW    = 27;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic [3:0]    colID;
    logic [7:0]    readDelay;
    logic          l1a;
    logic [BW-1:0] bcstIn;
    logic [BW-1:0] colBCST;
    logic [4:0]    colHits;
    logic [45:0]   colData;
    logic          colRead;
    logic [45:0]   outData;
    logic          outLast;
    logic          outValid;
    logic          outReady;
    logic [7:0]    droppedL1A;

    col_readout_ctrl #(.BCSTWIDTH(BW), .FIFODEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .colID(colID), .readDelay(readDelay), .l1a(l1a),
        .bcstIn(bcstIn), .colBCST(colBCST), .colHits(colHits), .colData(colData),
        .colRead(colRead), .outData(outData), .outLast(outLast), .outValid(outValid),
        .outReady(outReady), .droppedL1A(droppedL1A)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [45:0] colQ[$];
    logic [46:0] outLog[$];
    int          rdCycles[$];

    // Event-level model state
    logic [46:0] mq[$];
    bit          mActive;
    bit          mDrainDone;
    int          mDrainAt;
    int          mL1aCnt;
    int          mHit;
    int          mDropped;
    logic [BW-1:0] expBcst;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [46:0] logEntry(input int i);
        return (i < outLog.size()) ? outLog[i] : 47'h0;
    endfunction

    function automatic logic [46:0] trailer(input int cnt, input logic [3:0] id, input int hits);
        logic [7:0] c8;
        logic [4:0] h5;
        c8 = 8'(cnt);
        h5 = 5'(hits);
        return {29'b0, c8, id, h5, 1'b1};
    endfunction

    // Compare process: one model step per cycle, sampled mid-cycle.
    initial begin
        bit wasActive, inDrain, inTrl, expRead;
        int pre;
        logic [46:0] head;
        mActive = 0; mDrainDone = 0; mDrainAt = 0; mL1aCnt = 0; mHit = 0; mDropped = 0;
        expBcst = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                mq.delete();
                mActive = 0; mDrainDone = 0; mL1aCnt = 0; mHit = 0; mDropped = 0;
                expBcst = '0;
                check("rst_outValid", 64'(outValid), 64'd0);
                check("rst_colRead", 64'(colRead), 64'd0);
                check("rst_colBCST", 64'(colBCST), 64'd0);
                check("rst_dropped", 64'(droppedL1A), 64'd0);
            end else begin
                wasActive = mActive;
                inDrain   = mActive && (cyc >= mDrainAt) && !mDrainDone;
                inTrl     = mActive && mDrainDone;
                pre       = mq.size();
                expRead   = inDrain && (colHits != 0) && (pre < DEPTH);
                head      = (pre != 0) ? mq[0] : 47'h0;
                check("colRead", 64'(colRead), 64'(expRead));
                check("colBCST", 64'(colBCST), 64'(expBcst));
                check("dropped", 64'(droppedL1A), 64'(mDropped));
                check("outValid", 64'(outValid), 64'(pre != 0));
                check("outWord", 64'({outData, outLast}), 64'(head));
                if (colRead) rdCycles.push_back(cyc);
                if (outValid && outReady) outLog.push_back({outData, outLast});
                if (pre != 0 && outReady) void'(mq.pop_front());
                if (expRead) begin
                    mq.push_back({colData, 1'b0});
                    if (mHit < 31) mHit++;
                end
                if (inDrain && colHits == 0) mDrainDone = 1;
                if (inTrl && pre < DEPTH) begin
                    mq.push_back(trailer(mL1aCnt, colID, mHit));
                    mActive = 0;
                    mDrainDone = 0;
                end
                if (l1a) begin
                    if (!wasActive) begin
                        mActive  = 1;
                        mDrainAt = cyc + int'(readDelay) + 2;
                        mL1aCnt  = (mL1aCnt + 1) % 256;
                        mHit     = 0;
                    end else if (mDropped < 255) begin
                        mDropped++;
                    end
                end
                expBcst = bcstIn;
            end
            cyc++;
        end
    end

    // Bottom-cell model: a hit is consumed on each edge that sees colRead high.
    initial begin
        bit rd;
        colHits = '0;
        colData = '0;
        forever begin
            @(negedge clk);
            rd = colRead;
            @(posedge clk);
            #1;
            if (rd && colQ.size() > 0) void'(colQ.pop_front());
            colHits = (colQ.size() > 31) ? 5'd31 : 5'(colQ.size());
            colData = (colQ.size() > 0) ? colQ[0] : 46'h0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int l1aCyc;

    task automatic pulseL1a();
        l1a = 1'b1;
        l1aCyc = cyc;
        tick(1);
        l1a = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while ((mActive || mq.size() != 0) && n < 3000) begin
            tick(1);
            n++;
        end
        check(name, 64'(n < 3000), 64'd1);
        tick(2);
    endtask

    function automatic logic [45:0] rndWord();
        return 46'({$urandom(), $urandom()});
    endfunction

    initial begin
        logic [45:0] h[6];
        rstn = 1'b0; colID = 4'd5; readDelay = 8'd0; l1a = 1'b0;
        bcstIn = '0; outReady = 1'b1;
        tick(3);
        rstn = 1'b1;
        tick(2);

        // Two hits with readDelay=3
        outLog.delete(); rdCycles.delete();
        h[0] = rndWord(); h[1] = rndWord();
        colQ.push_back(h[0]); colQ.push_back(h[1]);
        readDelay = 8'd3;
        tick(2);
        pulseL1a();
        waitIdle("A_timeout");
        check("A_nreads", 64'(rdCycles.size()), 64'd2);
        check("A_read0_cycle", 64'(rdCycles.size() > 0 ? rdCycles[0] : -1), 64'(l1aCyc + 5));
        check("A_read1_cycle", 64'(rdCycles.size() > 1 ? rdCycles[1] : -1), 64'(l1aCyc + 6));
        check("A_nwords", 64'(outLog.size()), 64'd3);
        check("A_word0", 64'(logEntry(0)), 64'({h[0], 1'b0}));
        check("A_word1", 64'(logEntry(1)), 64'({h[1], 1'b0}));
        check("A_trailer", 64'(logEntry(2)), 64'({29'b0, 8'd1, 4'd5, 5'd2, 1'b1}));

        // Empty column with readDelay=0
        outLog.delete(); rdCycles.delete();
        readDelay = 8'd0;
        pulseL1a();
        waitIdle("B_timeout");
        check("B_nreads", 64'(rdCycles.size()), 64'd0);
        check("B_nwords", 64'(outLog.size()), 64'd1);
        check("B_trailer", 64'(logEntry(0)), 64'({29'b0, 8'd2, 4'd5, 5'd0, 1'b1}));

        // FIFO-full stall with six hits
        outLog.delete();
        outReady = 1'b0; readDelay = 8'd2;
        for (int i = 0; i < 6; i++) begin h[i] = rndWord(); colQ.push_back(h[i]); end
        tick(2);
        pulseL1a();
        tick(20);
        check("C_left_in_column", 64'(colQ.size()), 64'd2);
        check("C_colRead_stalled", 64'(colRead), 64'd0);
        check("C_outValid", 64'(outValid), 64'd1);
        outReady = 1'b1;
        waitIdle("C_timeout");
        check("C_nwords", 64'(outLog.size()), 64'd7);
        for (int i = 0; i < 6; i++) check("C_word", 64'(logEntry(i)), 64'({h[i], 1'b0}));
        check("C_trailer", 64'(logEntry(6)), 64'({29'b0, 8'd3, 4'd5, 5'd6, 1'b1}));

        // Second L1A while draining is dropped
        outLog.delete();
        outReady = 1'b0; readDelay = 8'd1;
        for (int i = 0; i < 6; i++) colQ.push_back(rndWord());
        tick(2);
        pulseL1a();
        tick(8);
        pulseL1a();
        check("D_dropped", 64'(droppedL1A), 64'd1);
        outReady = 1'b1;
        waitIdle("D_timeout");
        check("D_trailer", 64'(logEntry(6)), 64'({29'b0, 8'd4, 4'd5, 5'd6, 1'b1}));

        // Reset in the middle of DRAIN
        outLog.delete();
        readDelay = 8'd0; outReady = 1'b1;
        for (int i = 0; i < 10; i++) colQ.push_back(rndWord());
        tick(2);
        pulseL1a();
        tick(3);
        check("E_reading", 64'(colRead), 64'd1);
        rstn = 1'b0;
        #1;
        check("E_rst_outValid", 64'(outValid), 64'd0);
        check("E_rst_colRead", 64'(colRead), 64'd0);
        tick(2);
        rstn = 1'b1;
        colQ.delete();
        tick(2);
        outLog.delete();
        pulseL1a();
        waitIdle("E_timeout");
        check("E_trailer", 64'(logEntry(outLog.size() - 1)), 64'({29'b0, 8'd1, 4'd5, 5'd0, 1'b1}));

        // Dropped-L1A saturation
        readDelay = 8'd255;
        l1a = 1'b1;
        tick(300);
        l1a = 1'b0;
        check("F_dropped_sat", 64'(droppedL1A), 64'd255);
        waitIdle("F_timeout");
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick(1);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            l1a       = ($urandom_range(15) == 0);
            readDelay = 8'($urandom_range(7));
            outReady  = ($urandom_range(3) != 0);
            bcstIn    = BW'($urandom());
            if ($urandom_range(63) == 0) colID = 4'($urandom());
            if (colQ.size() < 20 && $urandom_range(7) == 0) colQ.push_back(rndWord());
            if ($urandom_range(499) == 0) begin
                rstn = 1'b0;
                tick(2);
                rstn = 1'b1;
            end
            tick(1);
        end
        l1a = 1'b0;
        outReady = 1'b1;
        waitIdle("R_timeout");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/col_readout_ctrl.md
COL_READOUT_CTRL -- requirements
Module: col_readout_ctrl

Interface
REQ-001 Parameter BCSTWIDTH, default 27, width of the broadcast word driven up the column.
REQ-002 Parameter FIFODEPTH, default 4, output FIFO depth in 46-bit words.
REQ-003 clk  in  1  40MHz clock; single clock domain.
REQ-004 rstn  in  1  reset, asynchronous assert, active-low.
REQ-005 colID  in  4  column number, inserted in the trailer word.
REQ-006 readDelay  in  8  cycles to wait between L1A and the start of draining.
REQ-007 l1a  in  1  single-cycle trigger request.
REQ-008 bcstIn  in  BCSTWIDTH  global broadcast word.
REQ-009 colBCST  out  BCSTWIDTH  registered bcstIn, fed to the bottom cell of the column (dnBCST side).
REQ-010 colHits  in  5  number of unread hits at the bottom of the column (dnHits side).
REQ-011 colData  in  46  hit word at the bottom of the column, valid in the same cycle as colHits!=0.
REQ-012 colRead  out  1  consume strobe for the bottom cell (dnRead side).
REQ-013 outData  out  46  FIFO head word.
REQ-014 outLast  out  1  head word is a trailer.
REQ-015 outValid  out  1  FIFO not empty.
REQ-016 outReady  in  1  downstream accepts head word.
REQ-017 droppedL1A  out  8  count of rejected L1As.

Function
REQ-018 colBCST SHALL equal bcstIn delayed by one clk edge.
REQ-019 States SHALL be: IDLE, WAIT, DRAIN, TRAILER.
- IDLE: on l1a=1, load dlyCnt=readDelay, clear hitCnt, increment l1aCnt (8-bit, wraps), go to WAIT.
- WAIT: dlyCnt==0 -> DRAIN; otherwise decrement dlyCnt.
- DRAIN: colHits==0 -> TRAILER; otherwise stay.
- TRAILER: push trailer when FIFO count<FIFODEPTH, then go to IDLE; otherwise hold.
REQ-020 DRAIN SHALL be entered exactly readDelay+1 edges after the edge that samples l1a.
REQ-021 colRead SHALL be combinational and SHALL equal (state==DRAIN) && (colHits!=0) && (fifoCount<FIFODEPTH).
REQ-022 On every cycle with colRead=1, the FSM SHALL push {colData, last=0} and increment hitCnt (5-bit, saturating at 31).
REQ-023 The trailer word SHALL be {29'b0, l1aCnt[7:0], colID[3:0], hitCnt[4:0]} with last=1; hitCnt excludes the trailer.
REQ-024 l1a in any state other than IDLE SHALL be ignored and SHALL increment droppedL1A, saturating at 255.
REQ-025 FIFO: outValid=(count!=0). Pop occurs when outValid&&outReady. Push and pop may coincide. Push eligibility uses the registered count only, so a full FIFO with a simultaneous pop still blocks the push. Order is first-in first-out.
REQ-026 outData/outLast SHALL be 0 when the FIFO is empty.
REQ-027 A FIFO-full stall SHALL NOT lose or duplicate column words; colRead stays low until space exists.

Reset
REQ-028 rstn=0 SHALL immediately force state=IDLE, FIFO empty, and outValid=0, colRead=0, colBCST=0, droppedL1A=0, l1aCnt=0, hitCnt=0, dlyCnt=0.
REQ-029 Reset during WAIT, DRAIN or TRAILER SHALL abort the event with no trailer; after release, the block resumes from IDLE.

Verification
REQ-030 readDelay=3, l1a at edge 0, column holds 2 hits (A,B), outReady=1 -> colRead high at edges 4 and 5; output sequence is A, B, then trailer {l1aCnt=1, colID, hitCnt=2, last=1}.
REQ-031 readDelay=0, colHits=0 -> DRAIN for 1 cycle; a trailer with hitCnt=0 follows, and no colRead occurs.
REQ-032 FIFODEPTH=4, outReady=0, 6 hits -> 4 words pushed, colRead low; outReady=1 -> remaining 2 hits plus trailer, 7 words in order, none lost.
REQ-033 Second l1a during DRAIN -> droppedL1A=1; the trailer l1aCnt is unchanged by the dropped trigger.
REQ-034 rstn pulsed low mid-DRAIN -> outValid=0 and colRead=0 immediately; the next l1a produces a fresh event with l1aCnt=1.
REQ-035 300 l1a pulses while busy -> droppedL1A saturates at 255.
